// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI4 write-burst master.
// Optional macro AXI_WR_4K_BOUNDARY_CHECK_EN adds the ERR state and the 4 KB page check.
package axi_wr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AW   = 3'd1,
      ST_W    = 3'd2,
      ST_B    = 3'd3
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
      ,
      ST_ERR  = 3'd4
`endif
   } axi_wr_state_t;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         AXI_PAGE_BYTES  = 4096;

   // True when a burst of len+1 beats of strb_w bytes starting at page offset offs spills past the page.
   function automatic logic crosses_page(input logic [11:0] offs, input logic [7:0] len,
                                         input int strb_w);
      return (int'(offs) + (int'(len) + 1) * strb_w) > AXI_PAGE_BYTES;
   endfunction

endpackage

// File: rtl/axi_wr_burst_master.sv
// Command + data stream to AXI4 INCR write bursts, one burst outstanding at a time.
// Macro AXI_WR_4K_BOUNDARY_CHECK_EN: reject bursts crossing a 4 KB page with SLVERR, no AXI traffic.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a command (blocked the cycle done_valid is high)
// ST_AW   | address phase, awaddr/awlen held from registers
// ST_W    | data beats passed straight through from din_*
// ST_B    | waiting for write response
// ST_ERR  | page-crossing command rejected, report SLVERR (macro only)
module axi_wr_burst_master
   import axi_wr_pkg::*;
#(
   parameter int  DATA_WIDTH = 256,
   parameter int  ADDR_WIDTH = 32,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk_domain_a,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic [STRB_WIDTH-1:0] din_strb,
   output logic                  done_valid,
   output logic [1:0]            done_resp,
   output logic                  axi_awvalid,
   input  logic                  axi_awready,
   output logic [ADDR_WIDTH-1:0] axi_awaddr,
   output logic [7:0]            axi_awlen,
   output logic [2:0]            axi_awsize,
   output logic [1:0]            axi_awburst,
   output logic                  axi_wvalid,
   input  logic                  axi_wready,
   output logic [DATA_WIDTH-1:0] axi_wdata,
   output logic [STRB_WIDTH-1:0] axi_wstrb,
   output logic                  axi_wlast,
   input  logic                  axi_bvalid,
   output logic                  axi_bready,
   input  logic [1:0]            axi_bresp
);

   axi_wr_state_t         state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_cnt;
   logic                  cmd_hs, w_hs, b_hs, err_now;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign w_hs   = axi_wvalid && axi_wready;
   assign b_hs   = axi_bvalid && axi_bready;

`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
   assign err_now = (state == ST_ERR);
`else
   assign err_now = 1'b0;
`endif

   assign axi_awaddr  = addr_q;
   assign axi_awlen   = len_q;
   assign axi_awsize  = 3'($clog2(STRB_WIDTH));
   assign axi_awburst = AXI_BURST_INCR;
   assign axi_wdata   = din_data;
   assign axi_wstrb   = din_strb;

   always_ff @(posedge clk_domain_a) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt   <= '0;
         done_valid <= 1'b0;
         done_resp  <= AXI_RESP_OKAY;
      end else begin
         state      <= state_nxt;
         done_valid <= b_hs || err_now;
         if (cmd_hs) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
         end else if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (err_now)
            done_resp <= AXI_RESP_SLVERR;
         else if (b_hs)
            done_resp <= axi_bresp;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      din_ready   = 1'b0;
      axi_wlast   = 1'b0;
      axi_bready  = 1'b0;
      case (state)
         ST_IDLE: begin
            // Held low through the done_valid cycle so the requester sees completion first.
            cmd_ready = !done_valid && !rst;
            if (cmd_valid && !done_valid) begin
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
               if (crosses_page(cmd_addr[11:0], cmd_len, STRB_WIDTH))
                  state_nxt = ST_ERR;
               else
                  state_nxt = ST_AW;
`else
               state_nxt = ST_AW;
`endif
            end
         end
         ST_AW: begin
            axi_awvalid = 1'b1;
            if (axi_awready)
               state_nxt = ST_W;
         end
         ST_W: begin
            axi_wvalid = din_valid;
            din_ready  = axi_wready;
            axi_wlast  = (beat_cnt == len_q);
            if (din_valid && axi_wready && (beat_cnt == len_q))
               state_nxt = ST_B;
         end
         ST_B: begin
            axi_bready = 1'b1;
            if (axi_bvalid)
               state_nxt = ST_IDLE;
         end
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
         ST_ERR: state_nxt = ST_IDLE;
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Randomized bench for axi_wr_burst_master against a transaction-level burst model.
// Define AXI_WR_4K_BOUNDARY_CHECK_EN for both bench and RTL to exercise the page check.
module tb_axi_wr_burst_master;

   localparam int DW = 256;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [31:0]   cmd_addr;
   logic [7:0]    cmd_len;
   logic          din_valid, din_ready;
   logic [DW-1:0] din_data;
   logic [SW-1:0] din_strb;
   logic          done_valid;
   logic [1:0]    done_resp;
   logic          axi_awvalid, axi_awready;
   logic [31:0]   axi_awaddr;
   logic [7:0]    axi_awlen;
   logic [2:0]    axi_awsize;
   logic [1:0]    axi_awburst;
   logic          axi_wvalid, axi_wready;
   logic [DW-1:0] axi_wdata;
   logic [SW-1:0] axi_wstrb;
   logic          axi_wlast;
   logic          axi_bvalid, axi_bready;
   logic [1:0]    axi_bresp;

   axi_wr_burst_master dut (
      .clk_domain_a(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_strb(din_strb),
      .done_valid(done_valid), .done_resp(done_resp),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // slave / source knobs
   int       aw_delay = 0, wready_pct = 100, din_pct = 100, b_delay = 0;
   bit       b_noise = 0;
   logic [1:0] b_resp_cfg = 2'b00;

   logic [DW-1:0] src_data [256];
   logic [SW-1:0] src_strb [256];
   int src_idx = 0, src_len = 0;
   bit b_pend = 0;
   int b_wait = 0, aw_cnt = 0;

   // events recorded by the compare process
   int cyc = 0, cmd_cnt = 0, done_cnt = 0, aw_cnt_tot = 0, beat_tot = 0, wlast_tot = 0;
   int ev_cmd = 0, ev_aw = 0, ev_awhs = 0, ev_done = 0, ev_ready = 0;
   logic [1:0] last_resp = 2'b00;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit page_cross(input logic [31:0] addr, input logic [7:0] len);
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
      return (int'(addr % 4096) + (int'(len) + 1) * SW) > 4096;
`else
      return 1'b0;
`endif
   endfunction

   // data source: presents the current burst's beats, junk otherwise
   initial begin
      din_valid = 0; din_data = '0; din_strb = '0;
      forever begin
         @(posedge clk); #2;
         if (!rst && src_idx < src_len) begin
            din_valid = ($urandom_range(99) < din_pct);
            din_data  = src_data[src_idx];
            din_strb  = src_strb[src_idx];
         end else begin
            din_valid = ($urandom_range(3) == 0);
            din_data  = rand_data();
            din_strb  = $urandom;
         end
      end
   end

   // AXI slave
   initial begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
            aw_cnt = 0; b_pend = 0; b_wait = 0;
         end else begin
            if (axi_awvalid) begin
               axi_awready = (aw_cnt >= aw_delay);
               aw_cnt++;
            end else begin
               axi_awready = 0;
               aw_cnt = 0;
            end
            axi_wready = ($urandom_range(99) < wready_pct);
            if (b_pend) begin
               if (b_wait >= b_delay) begin
                  axi_bvalid = 1; axi_bresp = b_resp_cfg;
               end else begin
                  axi_bvalid = 0; b_wait++;
               end
            end else if (b_noise && $urandom_range(7) == 0) begin
               axi_bvalid = 1; axi_bresp = 2'($urandom);
            end else begin
               axi_bvalid = 0;
            end
         end
      end
   end

   // Transaction model: one burst = command, address, len+1 beats, response, done, then idle again.
   initial begin
      bit m_busy, m_aw_done, m_b_done, m_done_pend, m_err, m_err_fired, prev_rst, aw_flag, rdy_flag;
      int m_beats, m_len;
      logic [31:0] m_addr;
      logic [1:0]  m_resp;
      bit e_cmd_ready, e_awvalid, in_w, in_b, e_wlast, hs_cmd, hs_w;
      m_busy = 0; m_aw_done = 0; m_b_done = 0; m_done_pend = 0; m_err = 0; m_err_fired = 0;
      prev_rst = 0; aw_flag = 0; rdy_flag = 0; m_beats = 0; m_len = 0; m_addr = 0; m_resp = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            if (prev_rst) begin
               chk("rst_awvalid", axi_awvalid, 0);
               chk("rst_wvalid", axi_wvalid, 0);
               chk("rst_bready", axi_bready, 0);
               chk("rst_din_ready", din_ready, 0);
               chk("rst_done_valid", done_valid, 0);
               chk("rst_done_resp", done_resp, 0);
               chk("rst_awaddr", axi_awaddr, 0);
               chk("rst_awlen", axi_awlen, 0);
            end
            m_busy = 0; m_aw_done = 0; m_b_done = 0; m_done_pend = 0; m_err = 0; m_err_fired = 0;
            m_beats = 0; prev_rst = 1; rdy_flag = 0;
            continue;
         end
         prev_rst = 0;

         e_cmd_ready = !m_busy;
         e_awvalid   = m_busy && !m_err && !m_aw_done;
         in_w        = m_busy && !m_err && m_aw_done && (m_beats <= m_len);
         in_b        = m_busy && !m_err && (m_beats == m_len + 1) && !m_b_done;
         e_wlast     = in_w && (m_beats == m_len);
         hs_cmd      = e_cmd_ready && cmd_valid;
         hs_w        = in_w && din_valid && axi_wready;

         chk("cmd_ready", cmd_ready, e_cmd_ready);
         chk("awvalid", axi_awvalid, e_awvalid);
         chk("wvalid", axi_wvalid, in_w && din_valid);
         chk("din_ready", din_ready, in_w && axi_wready);
         chk("wlast", axi_wlast, e_wlast);
         chk("bready", axi_bready, in_b);
         chk("done_valid", done_valid, m_done_pend);
         if (m_done_pend) chk("done_resp", done_resp, m_resp);
         if (e_awvalid) begin
            chk("awaddr", axi_awaddr, m_addr);
            chk("awlen", axi_awlen, m_len);
            chk("awsize", axi_awsize, 3'd5);
            chk("awburst", axi_awburst, 2'b01);
         end
         if (hs_w) begin
            chk("wdata", axi_wdata, src_data[m_beats]);
            chk("wstrb", axi_wstrb, src_strb[m_beats]);
         end

         // event log for literal timing checks
         if (hs_cmd) begin ev_cmd = cyc; cmd_cnt++; aw_flag = 0; end
         if (axi_awvalid && !aw_flag) begin ev_aw = cyc; aw_flag = 1; aw_cnt_tot++; end
         if (axi_awvalid && axi_awready) ev_awhs = cyc;
         if (axi_wvalid && axi_wready) begin
            beat_tot++;
            if (axi_wlast) wlast_tot++;
         end
         if (rdy_flag && cmd_ready) begin ev_ready = cyc; rdy_flag = 0; end
         if (done_valid) begin ev_done = cyc; done_cnt++; last_resp = done_resp; rdy_flag = 1; end

         // slave bookkeeping follows the DUT's actual handshakes
         if (axi_wvalid && axi_wready && axi_wlast) begin b_pend = 1; b_wait = 0; end
         if (axi_bvalid && axi_bready) b_pend = 0;

         // advance the model
         if (hs_w) begin m_beats++; src_idx++; end
         if (e_awvalid && axi_awready) m_aw_done = 1;
         if (m_done_pend) begin m_done_pend = 0; m_busy = 0; end
         if (in_b && axi_bvalid) begin m_b_done = 1; m_done_pend = 1; m_resp = axi_bresp; end
         if (m_busy && m_err && !m_err_fired) begin m_err_fired = 1; m_done_pend = 1; m_resp = 2'b10; end
         if (hs_cmd) begin
            m_busy = 1; m_aw_done = 0; m_b_done = 0; m_beats = 0;
            m_addr = cmd_addr; m_len = int'(cmd_len);
            m_err = page_cross(cmd_addr, cmd_len); m_err_fired = 0;
         end
      end
   end

   task automatic do_cmd(input logic [31:0] addr, input logic [7:0] len, input int abort_at);
      int t, c0, d0;
      for (int i = 0; i <= int'(len); i++) begin
         src_data[i] = rand_data();
         src_strb[i] = $urandom;
      end
      src_idx = 0;
      src_len = page_cross(addr, len) ? 0 : int'(len) + 1;
      c0 = cmd_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      cmd_valid = 1; cmd_addr = addr; cmd_len = len;
      t = 0;
      while (cmd_cnt == c0 && t < 200) begin @(posedge clk); #1; t++; end
      cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom);
      if (cmd_cnt == c0) chk("cmd_accept_timeout", 0, 1);
      if (abort_at >= 0) begin
         t = 0;
         while (src_idx < abort_at && t < 2000) begin @(posedge clk); #1; t++; end
         if (src_idx < abort_at) chk("abort_wait_timeout", 0, 1);
         rst = 1; src_len = 0;
         repeat (2) begin @(posedge clk); #1; end
         rst = 0;
         return;
      end
      t = 0;
      while (done_cnt == d0 && t < 3000) begin @(posedge clk); #1; t++; end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      int b0, w0, a0;
      rst = 1; cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 0;
      @(posedge clk); #1;

      // zero-wait len=3 burst at 0x1000
      aw_delay = 0; wready_pct = 100; din_pct = 100; b_delay = 0; b_noise = 0; b_resp_cfg = 2'b00;
      b0 = beat_tot; w0 = wlast_tot;
      do_cmd(32'h0000_1000, 8'd3, -1);
      chk("t1_aw_lat", ev_aw - ev_cmd, 1);
      chk("t1_done_lat", ev_done - ev_cmd, 7);
      chk("t1_beats", beat_tot - b0, 4);
      chk("t1_wlast", wlast_tot - w0, 1);
      chk("t1_resp", last_resp, 2'b00);
      chk("t1_ready_lat", ev_ready - ev_done, 1);

      // single-beat burst, minimum spacing
      b0 = beat_tot; w0 = wlast_tot;
      do_cmd(32'h0000_2000, 8'd0, -1);
      chk("t2_done_lat", ev_done - ev_cmd, 4);
      chk("t2_ready_lat", ev_ready - ev_cmd, 5);
      chk("t2_beats", beat_tot - b0, 1);
      chk("t2_wlast", wlast_tot - w0, 1);

      // delayed awready, gappy data
      aw_delay = 5; wready_pct = 60; din_pct = 60;
      b0 = beat_tot;
      do_cmd(32'h0000_3040, 8'd5, -1);
      chk("t3_awhs_lat", ev_awhs - ev_aw, 5);
      chk("t3_beats", beat_tot - b0, 6);

      // SLVERR from slave, stray bvalid pulses during the burst
      aw_delay = 1; wready_pct = 80; din_pct = 80; b_delay = 2; b_noise = 1; b_resp_cfg = 2'b10;
      do_cmd(32'h0000_4000, 8'd4, -1);
      chk("t4_resp", last_resp, 2'b10);

      // reset after two of eight beats, then a clean burst
      b_noise = 0; b_resp_cfg = 2'b00; b_delay = 0; aw_delay = 0;
      do_cmd(32'h0000_5000, 8'd7, 2);
      b0 = beat_tot;
      do_cmd(32'h0000_6000, 8'd2, -1);
      chk("t5_beats", beat_tot - b0, 3);
      chk("t5_resp", last_resp, 2'b00);

`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
      a0 = aw_cnt_tot;
      do_cmd(32'h0000_0FE0, 8'd1, -1);
      chk("t6_err_resp", last_resp, 2'b10);
      chk("t6_err_lat", ev_done - ev_cmd, 2);
      chk("t6_no_aw", aw_cnt_tot - a0, 0);
      b0 = beat_tot;
      do_cmd(32'h0000_0FC0, 8'd1, -1);
      chk("t6_ok_resp", last_resp, 2'b00);
      chk("t6_ok_beats", beat_tot - b0, 2);
`else
      a0 = 0;
`endif

      // randomized bursts
      b_noise = 1;
      for (int n = 0; n < 25; n++) begin
         logic [7:0] ln;
         aw_delay   = $urandom_range(4);
         wready_pct = $urandom_range(40, 100);
         din_pct    = $urandom_range(40, 100);
         b_delay    = $urandom_range(3);
         b_resp_cfg = 2'($urandom);
         ln = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
         a0 = done_cnt;
         do_cmd($urandom, ln, -1);
         chk("rand_done_count", done_cnt - a0, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_wr_burst_master.md
# axi_wr_burst_master

Converts a simple command-plus-data stream into AXI4 write bursts that drive the `axi_aw*`/`axi_w*`/`axi_b*` slave channels of `systemverilog_ip`. It sits directly upstream of that IP's write port, in the `clk_domain_a` domain. Each accepted command produces one INCR burst: one AW handshake, `len+1` W beats, and one B response. The B response is reported back to the requester.

## Interface
Parameters:
- DATA_WIDTH, 256, W data width in bits; must be a power of two, at least 8.
- ADDR_WIDTH, 32, AW address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width; derived, not overridden.

Ports:
- clk_domain_a  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`.
- cmd_addr  in  ADDR_WIDTH  burst start byte address.
- cmd_len  in  8  beats minus one (0..255).
- din_valid  in  1  write data beat available.
- din_ready  out  1  beat consumed when `din_valid && din_ready`.
- din_data  in  DATA_WIDTH  beat payload.
- din_strb  in  STRB_WIDTH  beat byte enables.
- done_valid  out  1  one-cycle pulse: burst complete.
- done_resp  out  2  BRESP, or the locally generated error; valid with `done_valid`.
- axi_awvalid/awready  out/in  1  AW handshake.
- axi_awaddr  out  ADDR_WIDTH  start address.
- axi_awlen  out  8  equals `cmd_len`.
- axi_awsize  out  3  constant `$clog2(STRB_WIDTH)` (5 at default).
- axi_awburst  out  2  constant 2'b01 (INCR).
- axi_wvalid/wready  out/in  1  W handshake.
- axi_wdata  out  DATA_WIDTH  beat data.
- axi_wstrb  out  STRB_WIDTH  beat strobes.
- axi_wlast  out  1  asserted on the final beat.
- axi_bvalid/bready  in/out  1  B handshake.
- axi_bresp  in  2  write response.

## Operation
- FSM states: IDLE, AW, W, B, ERR.
- IDLE:
  - `cmd_ready=1`.
  - On command handshake, register `addr` and `len` into `addr_q`/`len_q`, clear `beat_cnt`, go to AW.
- AW:
  - `axi_awvalid=1`; `awaddr`/`awlen` are driven from the registers and held stable until `axi_awready`.
  - On handshake go to W.
- W:
  - Pass-through: `axi_wvalid=din_valid`, `din_ready=axi_wready`, `wdata/wstrb=din_*`.
  - `axi_wlast=(beat_cnt==len_q)`.
  - Each W handshake increments `beat_cnt` (8 bits).
  - The handshake with `wlast` goes to B.
  - `din_ready=0` in every state other than W.
- B:
  - `axi_bready=1`.
  - On `axi_bvalid`, register `done_resp<=axi_bresp` and `done_valid<=1` for one cycle, then go to IDLE.
- One burst is outstanding at a time. `cmd_ready` stays low from acceptance until the cycle after `done_valid`.
- W beats are never issued before the AW handshake completes.
- Extra `din_valid` beats outside the W state are not consumed.
- `cmd_len=0` produces a single beat with `wlast` set on it.
- `bvalid` arriving in any state other than B is ignored, because `bready=0` there.
- Reset mid-burst:
  - All control registers clear and the FSM returns to IDLE.
  - The partial burst is abandoned; the downstream IP is reset by the same system reset.

## Timing
- Reset values: `cmd_ready=0` during reset and 1 the first cycle after it. `axi_awvalid`, `axi_wvalid`, `axi_bready`, `din_ready`, `done_valid`, `done_resp`, `axi_awaddr`, and `axi_awlen` are all 0.
- Command handshake at cycle N puts `axi_awvalid=1` at cycle N+1.
- AW handshake at cycle M: the first beat is eligible at M+1.
- W path: zero-cycle combinational path; no storage.
- B handshake at cycle K: `done_valid` at K+1, `cmd_ready` at K+2.
- Minimum command-to-command spacing for len=0 with zero-wait slave: 5 cycles.

## Configuration
- Macro `AXI_WR_4K_BOUNDARY_CHECK_EN`:
  - Defined: on acceptance, if `cmd_addr[11:0] + (cmd_len+1)*STRB_WIDTH > 4096`, the FSM goes to ERR instead of AW. ERR issues no AXI traffic and consumes no data. The next cycle it pulses `done_valid` with `done_resp=2'b10` (SLVERR), then returns to IDLE.
  - Not defined: no check and no ERR state; every command issues a burst.

## Structure
- Package `axi_wr_pkg`:
  - FSM state enum `axi_wr_state_t`.
  - `AXI_BURST_INCR=2'b01`.
  - `AXI_RESP_OKAY=2'b00` and `AXI_RESP_SLVERR=2'b10`.
  - 4 KB page constant `AXI_PAGE_BYTES=4096`.
- No sub-module: the FSM, beat counter, and registers fit in one file.

## Test plan
- cmd addr=0x1000, len=3; slave always ready; 4 data beats → AW at N+1, 4 W beats with `wlast` on the 4th, BRESP OKAY → `done_valid`, `done_resp=00`.
- len=0 → single beat with `wlast=1` on it; `cmd_ready` low until the cycle after `done_valid`.
- `awready` delayed 5 cycles, random `wready`/`din_valid` gaps → `awaddr`/`awlen` stable while waiting, no W beat before the AW handshake, exactly len+1 beats in order.
- `bresp=2'b10` from slave → `done_resp=2'b10`; `bvalid` pulsed in the W state is ignored.
- `rst` asserted after 2 of 8 beats → all outputs are at reset values the next cycle, and a fresh command completes normally.
- With `AXI_WR_4K_BOUNDARY_CHECK_EN`: addr=0x0FE0, len=1 (64 B crosses 4 KB) → no `awvalid`, `done_resp=2'b10`. Addr=0x0FC0, len=1 → normal burst.
